// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU sources, the register file and its read ports.
// The arbiter sits on the slave side; the master side is the surrounding pipeline.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid_i;
  logic [4:0]      alu_addr_i;
  logic [XLEN-1:0] alu_data_i;
  logic            lsu_valid_i;
  logic            lsu_ready_o;
  logic [4:0]      lsu_addr_i;
  logic [XLEN-1:0] lsu_data_i;
  logic            write_enable_o;
  logic [4:0]      write_addr_o;
  logic [XLEN-1:0] write_data_o;
  logic [4:0]      rd_addr1_i;
  logic [4:0]      rd_addr2_i;
  logic            fwd1_hit_o;
  logic [XLEN-1:0] fwd1_data_o;
  logic            fwd2_hit_o;
  logic [XLEN-1:0] fwd2_data_o;
  logic            busy_o;

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    output rd_addr1_i, rd_addr2_i,
    input  lsu_ready_o,
    input  write_enable_o, write_addr_o, write_data_o,
    input  fwd1_hit_o, fwd1_data_o,
    input  fwd2_hit_o, fwd2_data_o,
    input  busy_o
  );

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  rd_addr1_i, rd_addr2_i,
    output lsu_ready_o,
    output write_enable_o, write_addr_o, write_data_o,
    output fwd1_hit_o, fwd1_data_o,
    output fwd2_hit_o, fwd2_data_o,
    output busy_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges ALU and LSU writeback into one register-file write port.
// Define RF_WB_FWD_EN to build forwarding of pending values to the read ports.
module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  rf_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      q_addr [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [CW-1:0]   count;

  logic            we_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;

  logic empty;
  logic alu_go;
  logic head_vld;
  logic lsu_xfer;
  logic lsu_keep;
  logic sel_head;
  logic sel_lsu;
  logic pop;
  logic push;

  assign empty    = (count == '0);
  assign alu_go   = bus.alu_valid_i && (bus.alu_addr_i != 5'd0);
  assign head_vld = !empty && q_vld[rptr];
  assign lsu_xfer = bus.lsu_valid_i && bus.lsu_ready_o;
  assign lsu_keep = lsu_xfer && (bus.lsu_addr_i != 5'd0);

  // ALU first, then a live head, then an LSU bypass into an empty FIFO
  assign sel_head = !alu_go && head_vld;
  assign sel_lsu  = !alu_go && empty && lsu_keep;

  // Killed heads drain even while the ALU owns the port
  assign pop  = !empty && (sel_head || !q_vld[rptr]);
  assign push = lsu_keep && !sel_lsu;

  assign bus.lsu_ready_o    = (count != CW'(DEPTH));
  assign bus.write_enable_o = we_q;
  assign bus.write_addr_o   = wa_q;
  assign bus.write_data_o   = wd_q;
  assign bus.busy_o         = !empty || we_q;

  // Output register, FIFO storage, WAW kill and pointer update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      we_q <= alu_go || sel_head || sel_lsu;
      unique case (1'b1)
        alu_go: begin
          wa_q <= bus.alu_addr_i;
          wd_q <= bus.alu_data_i;
        end
        sel_head: begin
          wa_q <= q_addr[rptr];
          wd_q <= q_data[rptr];
        end
        sel_lsu: begin
          wa_q <= bus.lsu_addr_i;
          wd_q <= bus.lsu_data_i;
        end
        default: begin
          wa_q <= wa_q;
          wd_q <= wd_q;
        end
      endcase
      if (alu_go) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_vld[i] && q_addr[i] == bus.alu_addr_i)
            q_vld[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_vld[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      if (push) begin
        q_vld[wptr]  <= 1'b1;
        q_addr[wptr] <= bus.lsu_addr_i;
        q_data[wptr] <= bus.lsu_data_i;
        wptr         <= wptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef RF_WB_FWD_EN
  function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] a);
    logic [XLEN:0] r;
    logic [AW-1:0] idx;
    r = '0;
    if (a != 5'd0) begin
      if (we_q && wa_q == a)
        r = {1'b1, wd_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rptr + AW'(i);
        if (CW'(i) < count && q_vld[idx] && q_addr[idx] == a)
          r = {1'b1, q_data[idx]};
      end
    end
    return r;
  endfunction

  // Youngest valid FIFO entry wins, then the output register
  always_comb begin
    {bus.fwd1_hit_o, bus.fwd1_data_o} = fwd_lookup(bus.rd_addr1_i);
    {bus.fwd2_hit_o, bus.fwd2_data_o} = fwd_lookup(bus.rd_addr2_i);
  end
`else
  logic unused_rd;
  assign unused_rd = ^{bus.rd_addr1_i, bus.rd_addr2_i};

  assign bus.fwd1_hit_o  = 1'b0;
  assign bus.fwd1_data_o = '0;
  assign bus.fwd2_hit_o  = 1'b0;
  assign bus.fwd2_data_o = '0;
`endif

endmodule
